mem_wb_skid_stage: RTL

MEM_WB_SKID_STAGE -- requirements
Module: mem_wb_skid_stage

---
 rtl/riscv_pkg.sv | 15 +
 rtl/load_formatter.sv | 36 +++
 rtl/mem_wb_skid_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath defaults and load funct3 encodings.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned RA_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/load_formatter.sv
// Combinational load extraction: selects byte/half by address offset and extends.
module load_formatter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword alignment ignores offset bit 0.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a one-entry skid buffer so in_ready is purely registered.
module mem_wb_skid_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned RA_W = RA_W_DEFAULT,
  parameter int unsigned SB_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] mem_rdata_mem,
  input  logic [XLEN-1:0] alu_res_mem,
  input  logic [2:0]      funct3_mem,
  input  logic [RA_W-1:0] rd_mem,
  input  logic            reg_write_mem,
  input  logic            mem_to_reg_mem,
  input  logic [SB_W-1:0] sb_mem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [RA_W-1:0] rd_wb,
  output logic            reg_write_wb,
  output logic [SB_W-1:0] sb_wb
);

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] in_data;

  load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .rdata  (mem_rdata_mem),
    .offset (alu_res_mem[1:0]),
    .funct3 (funct3_mem),
    .data   (load_data)
  );

  assign in_data = mem_to_reg_mem ? load_data : alu_res_mem;

  logic            out_valid_q,  out_valid_d;
  logic [XLEN-1:0] out_data_q,   out_data_d;
  logic [RA_W-1:0] out_rd_q,     out_rd_d;
  logic            out_rw_q,     out_rw_d;
  logic [SB_W-1:0] out_sb_q,     out_sb_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_data_q,  skid_data_d;
  logic [RA_W-1:0] skid_rd_q,    skid_rd_d;
  logic            skid_rw_q,    skid_rw_d;
  logic [SB_W-1:0] skid_sb_q,    skid_sb_d;

  logic in_fire;
  logic out_fire;

  assign in_ready = reset_n & ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_rd_d     = out_rd_q;
    out_rw_d     = out_rw_q;
    out_sb_d     = out_sb_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_rd_d    = skid_rd_q;
    skid_rw_d    = skid_rw_q;
    skid_sb_d    = skid_sb_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      // in_fire cannot coincide with a full skid, so the skid refill and the
      // direct input load are mutually exclusive.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_rd_d     = skid_rd_q;
        out_rw_d     = skid_rw_q;
        out_sb_d     = skid_sb_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_data_d = in_data;
        out_rd_d   = rd_mem;
        out_rw_d   = reg_write_mem;
        out_sb_d   = sb_mem;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_rd_d    = rd_mem;
        out_rw_d    = reg_write_mem;
        out_sb_d    = sb_mem;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_rd_d    = rd_mem;
        skid_rw_d    = reg_write_mem;
        skid_sb_d    = sb_mem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rd_q     <= '0;
      out_rw_q     <= 1'b0;
      out_sb_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_rd_q    <= '0;
      skid_rw_q    <= 1'b0;
      skid_sb_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rd_q     <= out_rd_d;
      out_rw_q     <= out_rw_d;
      out_sb_q     <= out_sb_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_rd_q    <= skid_rd_d;
      skid_rw_q    <= skid_rw_d;
      skid_sb_q    <= skid_sb_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign wb_data      = out_data_q;
  assign rd_wb        = out_rd_q;
  assign sb_wb        = out_sb_q;
  assign reg_write_wb = out_rw_q & (out_rd_q != '0) & out_valid_q;

endmodule
